// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter.
// Exports FSM state enum, read tag struct and read pipeline depth.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB,
    LOCK0,
    LOCK1
  } ram_arb_state_t;

  typedef struct packed {
    logic vld;
    logic port;
  } ram_rd_tag_t;

  localparam int RAM_RD_LATENCY = 1;
  // command stage plus RAM read latency
  localparam int TAG_DEPTH = RAM_RD_LATENCY + 1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// slave: arbiter side; master: requesters plus RAM device side.
interface ram_arbiter_if;

  logic       Req0;
  logic       We0;
  logic       Lock0;
  logic [7:0] Addr0;
  logic [7:0] WrData0;
  logic       Ack0;
  logic       RdValid0;
  logic [7:0] RdData0;

  logic       Req1;
  logic       We1;
  logic       Lock1;
  logic [7:0] Addr1;
  logic [7:0] WrData1;
  logic       Ack1;
  logic       RdValid1;
  logic [7:0] RdData1;

  logic       Cs;
  logic       Wen;
  logic       Oen;
  logic [7:0] Address;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  modport slave (
    input  Req0, We0, Lock0, Addr0, WrData0,
    input  Req1, We1, Lock1, Addr1, WrData1,
    input  DataOut,
    output Ack0, RdValid0, RdData0,
    output Ack1, RdValid1, RdData1,
    output Cs, Wen, Oen, Address, DataIn
  );

  modport master (
    output Req0, We0, Lock0, Addr0, WrData0,
    output Req1, We1, Lock1, Addr1, WrData1,
    output DataOut,
    input  Ack0, RdValid0, RdData0,
    input  Ack1, RdValid1, RdData1,
    input  Cs, Wen, Oen, Address, DataIn
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// req[1:0], last_grant in; one-hot (or zero) gnt[1:0] out.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between two requesters (round-robin + lock).
// Ports: Clk, Rst (async high), bus (ram_arbiter_if.slave).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int   MAX_LOCK  = 4,
  parameter logic RST_OWNER = 1'b0
) (
  input logic          Clk,
  input logic          Rst,
  ram_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_LOCK);

  ram_arb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_base;
  logic       last_q, last_d;

  logic [1:0] req, lock, we;
  logic [1:0] rr_gnt, gnt;
  logic       own, forced;
  logic       win, any;
  logic       we_w;
  logic [7:0] addr_w, wd_w;

  logic       cs_q, cs_d;
  logic       wen_q, wen_d;
  logic       oen_q, oen_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;

  ram_rd_tag_t [TAG_DEPTH-1:0] tag_q, tag_d;
  logic       rdv0, rdv1;
  logic [7:0] rd0_q, rd0_d;
  logic [7:0] rd1_q, rd1_d;

  assign req  = {bus.Req1, bus.Req0};
  assign lock = {bus.Lock1, bus.Lock0};
  assign we   = {bus.We1, bus.We0};

  rr_arb2 u_rr (
    .req       (req),
    .last_grant(last_q),
    .gnt       (rr_gnt)
  );

  assign own = (state_q == LOCK1);

  // Lock owner wins while requesting, unless it has used up its
  // run of grants and the other port is waiting.
  always_comb begin
    gnt    = rr_gnt;
    forced = 1'b0;
    if (state_q != ARB && req[own]) begin
      if (cnt_q >= CNT_MAX && req[~own]) begin
        forced = 1'b1;
        gnt    = own ? 2'b01 : 2'b10;
      end else begin
        gnt = own ? 2'b10 : 2'b01;
      end
    end
  end

  assign win    = gnt[1];
  assign any    = |gnt;
  assign we_w   = we[win];
  assign addr_w = win ? bus.Addr1 : bus.Addr0;
  assign wd_w   = win ? bus.WrData1 : bus.WrData0;

  always_comb begin
    state_d  = ARB;
    cnt_d    = '0;
    cnt_base = '0;
    last_d   = last_q;
    if (any) begin
      last_d = win;
      if (!forced && lock[win]) begin
        state_d = win ? LOCK1 : LOCK0;
        // run length restarts when ownership is newly taken
        if (state_q == state_d) begin
          cnt_base = cnt_q;
        end
        cnt_d = cnt_base + {3'b000, req[~win]};
      end
    end
  end

  always_comb begin
    cs_d   = any;
    wen_d  = any & we_w;
    oen_d  = any & ~we_w;
    addr_d = any ? addr_w : addr_q;
    din_d  = (any & we_w) ? wd_w : din_q;
    tag_d[0].vld  = oen_d;
    tag_d[0].port = win;
    for (int i = 1; i < TAG_DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign rdv0 = tag_q[TAG_DEPTH-1].vld & ~tag_q[TAG_DEPTH-1].port;
  assign rdv1 = tag_q[TAG_DEPTH-1].vld & tag_q[TAG_DEPTH-1].port;

  // read data passes through in its return cycle, then is held
  assign rd0_d = rdv0 ? bus.DataOut : rd0_q;
  assign rd1_d = rdv1 ? bus.DataOut : rd1_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ARB;
      cnt_q   <= '0;
      last_q  <= RST_OWNER;
      cs_q    <= 1'b0;
      wen_q   <= 1'b0;
      oen_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      tag_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      tag_q   <= tag_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign bus.Ack0     = gnt[0] & ~Rst;
  assign bus.Ack1     = gnt[1] & ~Rst;
  assign bus.RdValid0 = rdv0;
  assign bus.RdValid1 = rdv1;
  assign bus.RdData0  = rdv0 ? bus.DataOut : rd0_q;
  assign bus.RdData1  = rdv1 ? bus.DataOut : rd1_q;
  assign bus.Cs       = cs_q;
  assign bus.Wen      = wen_q;
  assign bus.Oen      = oen_q;
  assign bus.Address  = addr_q;
  assign bus.DataIn   = din_q;

endmodule
